pe_edge_feeder: RTL and testbench
=================================

# pe_edge_feeder

West-edge stream feeder for one systolic-array row: accepts operands on a valid/ready stream, buffers them in a small FIFO, and drives the first processing element's `west_i`, `inputs_valid_i` and `last_element_i` inputs. Elements are paced by the PE's `passthrough_valid_o`, fed back as an acknowledge. A programmable skew delays the first element of each vector so that row r starts r cycles after row 0. One instance sits at the west edge of each array row; a column variant is built by tying its outputs to `north_i`.

## Interface
- `DATA_WIDTH`, 32, operand width; equals the PE `DATA_WIDTH`.
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `SKEW`, 0, idle cycles inserted before the first element of each vector; 0..255.
- `clk_i` in 1: the single clock. Everything is synchronous to the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `s_data_i` in `DATA_WIDTH`: upstream operand.
- `s_last_i` in 1: marks the final operand of a vector.
- `s_valid_i` in 1: upstream valid.
- `s_ready_o` out 1: FIFO not full.
- `pe_data_o` out `DATA_WIDTH`: connects to the PE `west_i`.
- `pe_valid_o` out 1: one-cycle pulse; connects to the PE `inputs_valid_i`.
- `pe_last_o` out 1: one-cycle pulse coincident with `pe_valid_o`; connects to the PE `last_element_i`.
- `pe_ack_i` in 1: from the PE `passthrough_valid_o`.
- `busy_o` out 1: state is not IDLE, or the FIFO is not empty.
- `vector_done_o` out 1: one-cycle pulse when the last element of a vector is acknowledged.

## Operation
- **FIFO.** Each entry holds {last, data}.
  - Push when `s_valid_i && s_ready_o`.
  - Pop only on entry to ISSUE.
  - Occupancy counter runs 0..`DEPTH`; `s_ready_o` = (count != `DEPTH`).
- **FSM states:** IDLE, SKEW, ISSUE, WAIT_ACK.
- **IDLE.** Leave IDLE when the FIFO is not empty.
  - If `first_flag` is set and `SKEW` > 0: go to SKEW and load the skew counter with `SKEW`−1.
  - Otherwise go to ISSUE.
  - `first_flag` resets to 1.
- **SKEW.** Count down; go to ISSUE when the counter reaches 0.
- **ISSUE.** Lasts one cycle.
  - Registered outputs: `pe_data_o` ← head data, `pe_valid_o` ← 1, `pe_last_o` ← head last.
  - Pop the FIFO.
  - Load `first_flag` ← head last.
  - Go to WAIT_ACK.
- **WAIT_ACK.** `pe_valid_o` and `pe_last_o` are 0. `pe_data_o` holds its value, because the PE MAC reads `west_i` live throughout computation.
  - On `pe_ack_i`, if the issued element was last: pulse `vector_done_o`. Go to IDLE if the FIFO is empty or `first_flag` is set; otherwise go directly to ISSUE.
- **Stray acknowledge.** `pe_ack_i` outside WAIT_ACK is ignored.
- **Data path.** Data passes through unmodified; no arithmetic.
- **Push and pop in the same cycle.** Count is unchanged and both pointers advance. A write to an empty FIFO becomes visible to the FSM the next cycle.
- **Pointers.** Wrap modulo `DEPTH`.

## Timing
- **Reset values.** All outputs 0, except `s_ready_o` = 1.
  - FIFO empty, state IDLE, `first_flag` = 1.
  - Reset asserted mid-vector discards the FIFO and any in-flight element immediately. No `vector_done_o` is generated.
- **Latency, empty FIFO, `SKEW` = 0.** A push in cycle t gives `pe_valid_o` high in cycle t+2.
- **Latency with skew.** Add `SKEW` cycles before the first element of each vector only. Elements after the first are not skewed.
- **Back-to-back issue.** With `pe_ack_i` sampled in cycle a, the next `pe_valid_o` appears in cycle a+1. The PE is in IDLE then.
- **Hold window.** `pe_data_o` is stable from the `pe_valid_o` cycle through the ack cycle inclusive.
- **`vector_done_o`.** Asserted in cycle a+1 after the ack of the last element, and registered.
- **Simultaneous events.** `pe_ack_i` and a push in the same cycle are both honoured. A full FIFO plus a pop makes `s_ready_o` rise the following cycle.

## Structure
- A shared package `systolic_pkg` holds:
  - the `feeder_state_t` enum `{IDLE, SKEW, ISSUE, WAIT_ACK}`, 2-bit;
  - the `SKEW_W` constant = 8.
- Sub-module: `sync_fifo`, parameterised on width (`DATA_WIDTH`+1) and `DEPTH`. It exposes push/pop/full/empty/count, with the same clock and reset.
- The FSM, skew counter and output registers live in `pe_edge_feeder`.

## Test plan
- **Single vector, `SKEW` = 0, PE model with ack latency 5.**
  - Stimulus: push 3, 5, 7 (last on 7).
  - Required: `pe_valid_o` pulses carry 3, 5, 7, each issued the cycle after the previous ack. `pe_last_o` is high only with 7. `vector_done_o` is high one cycle after the ack of 7.
- **`SKEW` = 3.**
  - Stimulus: two vectors of 2 elements each, e.g. 1, 2(last) then 4, 5(last).
  - Required: 3 idle cycles before elements 1 and 4 only; no gap before 2 or 5 beyond the ack spacing.
- **FIFO full, PE ack withheld.**
  - Stimulus: hold off ack; push 9 elements with `DEPTH` = 8.
  - Required: `s_ready_o` = 0 after 8 accepted elements (1 already issued). Release ack: all 9 values are delivered in order and none are lost.
- **Hold check.**
  - Stimulus: ack delayed 20 cycles.
  - Required: `pe_data_o` is constant over the window. A spurious `pe_ack_i` pulse in IDLE produces no state change.
- **Reset mid-vector.**
  - Stimulus: assert `rst_i` during WAIT_ACK with 4 entries queued.
  - Required: outputs 0 and `s_ready_o` = 1 asynchronously. After release, a new vector 0xA(last) is issued with skew applied and no stale data.
- **Push/pop at wrap.**
  - Stimulus: 20 elements through `DEPTH` = 8 with ack latency 1.
  - Required: ordering is preserved across pointer wrap. `busy_o` falls exactly one cycle after the final `vector_done_o`.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array edge logic.
//   feeder_state_t : edge-feeder FSM encoding
//   SKEW_W         : width of the feeder skew counter (skew range 0..255)
package systolic_pkg;

    localparam int SKEW_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SKEW     = 2'd1,
        ISSUE    = 2'd2,
        WAIT_ACK = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   push_i / wdata_i    : write request and data (ignored when full)
//   pop_i / rdata_o     : read request (ignored when empty), head-of-queue data
//   full_o / empty_o    : occupancy flags
//   count_o             : occupancy 0..DEPTH
module sync_fifo
    import systolic_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CNT_DEPTH);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Occupancy next state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pe_edge_feeder.sv
// West-edge operand feeder for one systolic-array row.
//   s_data_i/s_last_i/s_valid_i/s_ready_o : upstream valid/ready stream
//   pe_data_o/pe_valid_o/pe_last_o        : drive PE west_i / inputs_valid_i / last_element_i
//   pe_ack_i                              : PE passthrough_valid_o, paces issue
//   busy_o                                : registered "FSM active or FIFO holds data"
//   vector_done_o                         : pulse after the last element of a vector is acked
// SKEW idle cycles precede the first element of every vector so row r lags row 0.
module pe_edge_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int SKEW       = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] pe_data_o,
    output logic                  pe_valid_o,
    output logic                  pe_last_o,
    input  logic                  pe_ack_i,
    output logic                  busy_o,
    output logic                  vector_done_o
);
    import systolic_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic              SKEW_EN   = (SKEW != 0);
    localparam logic [SKEW_W-1:0] SKEW_LOAD = SKEW_W'((SKEW > 0) ? (SKEW - 1) : 0);
    localparam logic [SKEW_W-1:0] SKEW_ONE  = SKEW_W'(1);

    feeder_state_t         state_q, state_d;
    logic [SKEW_W-1:0]     skew_cnt_q, skew_cnt_d;
    logic                  first_flag_q, first_flag_d;
    logic [DATA_WIDTH-1:0] pe_data_q, pe_data_d;
    logic                  pe_valid_q, pe_valid_d;
    logic                  pe_last_q, pe_last_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  issue_s;
    logic                  pop_s;
    logic [DATA_WIDTH:0]   head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_has_data_s;

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s_valid_i),
        .wdata_i ({s_last_i, s_data_i}),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign fifo_has_data_s = (fifo_count_s != '0);
    assign s_ready_o       = !fifo_full_s;
    assign pe_data_o       = pe_data_q;
    assign pe_valid_o      = pe_valid_q;
    assign pe_last_o       = pe_last_q;
    assign vector_done_o   = done_q;
    assign busy_o          = busy_q;

    // FSM next state; every path into ISSUE funnels through issue_s so pop and output load stay together.
    always_comb begin
        state_d      = state_q;
        skew_cnt_d   = skew_cnt_q;
        first_flag_d = first_flag_q;
        pe_data_d    = pe_data_q;   // data holds while the PE MAC reads it live
        pe_valid_d   = 1'b0;
        pe_last_d    = 1'b0;
        done_d       = 1'b0;
        issue_s      = 1'b0;
        pop_s        = 1'b0;
        busy_d       = (state_q != IDLE) || !fifo_empty_s;

        case (state_q)
            IDLE: begin
                if (fifo_has_data_s) begin
                    if (first_flag_q && SKEW_EN) begin
                        state_d    = systolic_pkg::SKEW;
                        skew_cnt_d = SKEW_LOAD;
                    end else begin
                        issue_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            systolic_pkg::SKEW: begin
                if (skew_cnt_q == '0) begin
                    issue_s = 1'b1;
                end else begin
                    skew_cnt_d = skew_cnt_q - SKEW_ONE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (pe_ack_i) begin
                    // first_flag_q still carries the last bit of the element being acked
                    done_d = first_flag_q;
                    if (!fifo_has_data_s || first_flag_q) begin
                        state_d = IDLE;
                    end else begin
                        issue_s = 1'b1;
                    end
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue_s) begin
            state_d      = ISSUE;
            pop_s        = 1'b1;
            pe_data_d    = head_s[DATA_WIDTH-1:0];
            pe_valid_d   = 1'b1;
            pe_last_d    = head_s[DATA_WIDTH];
            first_flag_d = head_s[DATA_WIDTH];
        end else begin
            pop_s = 1'b0;
        end
    end

    // State, skew counter and registered PE-facing outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            skew_cnt_q   <= '0;
            first_flag_q <= 1'b1;
            pe_data_q    <= '0;
            pe_valid_q   <= 1'b0;
            pe_last_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            skew_cnt_q   <= skew_cnt_d;
            first_flag_q <= first_flag_d;
            pe_data_q    <= pe_data_d;
            pe_valid_q   <= pe_valid_d;
            pe_last_q    <= pe_last_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_pe_edge_feeder.sv
// Directed bench for pe_edge_feeder: two instances (SKEW=0 and SKEW=3) share a
// muxed stimulus/observation path; a small PE model returns acks after a set latency.
module tb_pe_edge_feeder;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_last, s_valid;
    logic          sel;            // 0: SKEW=0 instance, 1: SKEW=3 instance
    logic          ack_model, ack_spur, ack_w;

    logic [DW-1:0] pe_data0, pe_data3, pe_data;
    logic          ready0, ready3, s_ready;
    logic          valid0, valid3, pe_valid;
    logic          last0, last3, pe_last;
    logic          busy0, busy3, busy;
    logic          done0, done3, done;

    assign ack_w    = ack_model | ack_spur;
    assign s_ready  = sel ? ready3   : ready0;
    assign pe_data  = sel ? pe_data3 : pe_data0;
    assign pe_valid = sel ? valid3   : valid0;
    assign pe_last  = sel ? last3    : last0;
    assign busy     = sel ? busy3    : busy0;
    assign done     = sel ? done3    : done0;

    pe_edge_feeder #(.DATA_WIDTH(DW), .DEPTH(8), .SKEW(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_last_i(s_last),
        .s_valid_i(s_valid & ~sel), .s_ready_o(ready0), .pe_data_o(pe_data0),
        .pe_valid_o(valid0), .pe_last_o(last0), .pe_ack_i(ack_w & ~sel),
        .busy_o(busy0), .vector_done_o(done0));

    pe_edge_feeder #(.DATA_WIDTH(DW), .DEPTH(8), .SKEW(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_last_i(s_last),
        .s_valid_i(s_valid & sel), .s_ready_o(ready3), .pe_data_o(pe_data3),
        .pe_valid_o(valid3), .pe_last_o(last3), .pe_ack_i(ack_w & sel),
        .busy_o(busy3), .vector_done_o(done3));

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint last_push_cyc;
    int     ack_lat  = 5;
    logic   ack_en   = 1'b1;
    int     ack_cnt  = 0;

    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    longint        got_cyc[$];
    longint        ack_q[$];
    longint        done_q[$];
    logic [DW-1:0] hold_val;
    logic          hold_on = 1'b0;
    int            hold_len = 0;
    int            hold_err = 0;
    logic          busy_prev = 1'b0;
    logic          ready_prev = 1'b1;
    longint        busy_fall = -1;
    longint        ready_rise = -1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic longint vdat(input int i);
        if (i < got_data.size()) return longint'(got_data[i]);
        else return -1;
    endfunction
    function automatic longint vlast(input int i);
        if (i < got_last.size()) return longint'(got_last[i]);
        else return -1;
    endfunction
    function automatic longint vcyc(input int i);
        if (i < got_cyc.size()) return got_cyc[i];
        else return -1000;
    endfunction
    function automatic longint acyc(input int i);
        if (i < ack_q.size()) return ack_q[i];
        else return -1000;
    endfunction
    function automatic longint dcyc(input int i);
        if (i < done_q.size()) return done_q[i];
        else return -1000;
    endfunction

    // cycle counter: value k throughout cycle k
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // PE model: ack ack_lat cycles after a pe_valid pulse, held off while ack_en is low
    initial begin
        ack_model = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ack_model = 1'b0;
            if (rst) begin
                ack_cnt = 0;
            end else if (pe_valid) begin
                ack_cnt = ack_lat;
            end else if (ack_cnt > 1) begin
                ack_cnt--;
            end else if (ack_cnt == 1 && ack_en) begin
                ack_cnt   = 0;
                ack_model = 1'b1;
                ack_q.push_back(cyc);
            end
        end
    end

    // monitor, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (pe_valid) begin
            got_data.push_back(pe_data);
            got_last.push_back(pe_last);
            got_cyc.push_back(cyc);
            hold_val = pe_data;
            hold_on  = 1'b1;
            hold_len = 0;
        end else if (hold_on) begin
            hold_len++;
            if (pe_data !== hold_val) hold_err++;
            if (ack_w) hold_on = 1'b0;
        end
        if (done) done_q.push_back(cyc);
        if (busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
        if (!ready_prev && s_ready) ready_rise = cyc;
        ready_prev = s_ready;
    end

    task automatic clear_rec();
        got_data.delete(); got_last.delete(); got_cyc.delete();
        ack_q.delete(); done_q.delete();
        hold_on = 1'b0; hold_len = 0; hold_err = 0;
        busy_fall = -1; ready_rise = -1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        int guard;
        guard   = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check_eq("push_ready", 64'(s_ready), 64'd1);
        last_push_cyc = cyc;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("done_count", 64'(done_q.size()), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        sel = 1'b0; ack_spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(s_ready), 64'd1);
        check_eq("rst_valid", 64'(pe_valid), 64'd0);
        check_eq("rst_data",  64'(pe_data), 64'd0);
        check_eq("rst_busy",  64'(busy), 64'd0);
        check_eq("rst_done",  64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single vector, SKEW=0, ack latency 5
        clear_rec();
        ack_lat = 5;
        push(32'd3, 1'b0); t0 = last_push_cyc;
        push(32'd5, 1'b0);
        push(32'd7, 1'b1);
        wait_done(1, 200);
        check_eq("t1_n",  64'(got_data.size()), 64'd3);
        check_eq("t1_d0", vdat(0), 64'd3);
        check_eq("t1_d1", vdat(1), 64'd5);
        check_eq("t1_d2", vdat(2), 64'd7);
        check_eq("t1_last", 64'({vlast(2) == 1, vlast(1) == 1, vlast(0) == 1}), 64'b100);
        check_eq("t1_lat",  vcyc(0) - t0, 64'd2);
        check_eq("t1_gap1", vcyc(1) - vcyc(0), 64'd6);
        check_eq("t1_gap2", vcyc(2) - vcyc(1), 64'd6);
        check_eq("t1_done", dcyc(0) - vcyc(2), 64'd6);
        repeat (3) @(posedge clk);
        #1;

        // SKEW=3, two vectors of two, ack latency 2
        sel = 1'b1;
        clear_rec();
        ack_lat = 2;
        push(32'd1, 1'b0); t0 = last_push_cyc;
        push(32'd2, 1'b1);
        push(32'd4, 1'b0);
        push(32'd5, 1'b1);
        wait_done(2, 300);
        check_eq("t2_n", 64'(got_data.size()), 64'd4);
        check_eq("t2_d", {vdat(0)[7:0], vdat(1)[7:0], vdat(2)[7:0], vdat(3)[7:0]}, 64'h01020405);
        check_eq("t2_last", 64'({vlast(3) == 1, vlast(2) == 1, vlast(1) == 1, vlast(0) == 1}), 64'b1010);
        check_eq("t2_lat", vcyc(0) - t0, 64'd5);
        check_eq("t2_gap1", vcyc(1) - vcyc(0), 64'd3);
        check_eq("t2_gap2", vcyc(2) - vcyc(0), 64'd10);
        check_eq("t2_gap3", vcyc(3) - vcyc(2), 64'd3);
        check_eq("t2_done0", dcyc(0) - vcyc(0), 64'd6);
        check_eq("t2_done1", dcyc(1) - vcyc(2), 64'd6);
        repeat (3) @(posedge clk);
        #1;

        // FIFO full with ack withheld, then release
        sel = 1'b0;
        clear_rec();
        ack_lat = 1;
        @(negedge clk) ack_en = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) push(DW'(32'h100 + i), i == 8);
        check_eq("t3_full", 64'(s_ready), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t3_still_full", 64'(s_ready), 64'd0);
        check_eq("t3_one_issued", 64'(got_data.size()), 64'd1);
        check_eq("t3_busy", 64'(busy), 64'd1);
        @(negedge clk) ack_en = 1'b1;
        wait_done(1, 300);
        check_eq("t3_n", 64'(got_data.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            check_eq("t3_data", vdat(i), 64'(32'h100 + i));
            check_eq("t3_last", vlast(i), 64'(i == 8));
        end
        check_eq("t3_ready_rise", ready_rise, acyc(0) + 1);
        repeat (3) @(posedge clk);
        #1;

        // spurious ack in IDLE, then hold window with 20-cycle ack latency
        clear_rec();
        ack_lat = 20;
        ack_spur = 1'b1;
        @(posedge clk);
        #1;
        ack_spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_spur_busy",  64'(busy), 64'd0);
        check_eq("t4_spur_valid", 64'(got_data.size()), 64'd0);
        check_eq("t4_spur_done",  64'(done_q.size()), 64'd0);
        push(32'hDEADBEEF, 1'b1); t0 = last_push_cyc;
        wait_done(1, 200);
        check_eq("t4_data", vdat(0), 64'hDEADBEEF);
        check_eq("t4_lat", vcyc(0) - t0, 64'd2);
        check_eq("t4_hold_err", 64'(hold_err), 64'd0);
        check_eq("t4_hold_len", 64'(hold_len), 64'd20);
        check_eq("t4_done", dcyc(0) - vcyc(0), 64'd21);
        repeat (3) @(posedge clk);
        #1;

        // reset during WAIT_ACK with 4 entries queued (SKEW=3 instance)
        sel = 1'b1;
        clear_rec();
        ack_lat = 10;
        for (int i = 0; i < 5; i++) push(DW'(32'h11 + i), i == 4);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_pre_issued", 64'(got_data.size()), 64'd1);
        check_eq("t5_pre_data", 64'(pe_data), 64'h11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_valid", 64'(pe_valid), 64'd0);
        check_eq("t5_rst_data",  64'(pe_data), 64'd0);
        check_eq("t5_rst_last",  64'(pe_last), 64'd0);
        check_eq("t5_rst_ready", 64'(s_ready), 64'd1);
        check_eq("t5_rst_busy",  64'(busy), 64'd0);
        check_eq("t5_rst_done",  64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_rec();
        push(32'hA, 1'b1); t0 = last_push_cyc;
        wait_done(1, 200);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t5_n", 64'(got_data.size()), 64'd1);
        check_eq("t5_data", vdat(0), 64'hA);
        check_eq("t5_last", vlast(0), 64'd1);
        check_eq("t5_lat", vcyc(0) - t0, 64'd5);
        check_eq("t5_ndone", 64'(done_q.size()), 64'd1);

        // 20 elements through the FIFO with ack latency 1 (pointer wrap)
        sel = 1'b0;
        clear_rec();
        ack_lat = 1;
        for (int i = 0; i < 20; i++) push(DW'(32'h200 + i), i == 19);
        wait_done(1, 500);
        repeat (4) @(posedge clk);
        #1;
        check_eq("t6_n", 64'(got_data.size()), 64'd20);
        for (int i = 0; i < 20; i++) begin
            check_eq("t6_data", vdat(i), 64'(32'h200 + i));
            check_eq("t6_last", vlast(i), 64'(i == 19));
        end
        check_eq("t6_busy_fall", busy_fall, dcyc(0) + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
